uart_rx_ctrl: RTL and testbench

Sequencer for the UART receive datapath. It turns the start-edge pulse from the receive capture logic into the bit-index count and the mid-bit sample strobe. The capture logic uses that count and strobe to assemble a 10-bit frame: start bit, 8 data bits, stop bit. It also adds start-bit validation, stop-bit checking, a run-time baud selection, and status outputs for the surrounding system.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_cnt.sv | 38 +++
 rtl/uart_rx_ctrl.sv | 111 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and baud divisor helper
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BIT  = 1'b1
    } state_e;

    localparam int FRAME_BITS = 10;
    localparam int NUM_W      = 4;
    localparam int CNT_W      = 13;

    localparam logic [CNT_W-1:0] DIV_9600   = 13'd5208;
    localparam logic [CNT_W-1:0] DIV_19200  = 13'd2604;
    localparam logic [CNT_W-1:0] DIV_57600  = 13'd868;
    localparam logic [CNT_W-1:0] DIV_115200 = 13'd434;

    function automatic logic [CNT_W-1:0] baud_div(input logic [1:0] sel, input int clk_freq);
        int rate;
        rate = 9600;
        case (sel)
            2'd1:    rate = 19200;
            2'd2:    rate = 57600;
            2'd3:    rate = 115200;
            default: rate = 9600;
        endcase
        return CNT_W'(clk_freq / rate);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with mid-bit and wrap strobes
module uart_baud_cnt
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] half,
    output logic [CNT_W-1:0] cnt,
    output logic             mid,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign mid  = run && (cnt_q == half);
    assign wrap = run && (cnt_q == div - CNT_W'(1));

    // Held at zero while idle so every bit period starts from a clean count.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!run || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - receive sequencer: bit index, mid-bit strobe, start/stop checks
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_enable,
    input  logic [1:0]       baud_sel,
    input  logic             rx_en,
    input  logic             rs232_rx,
    output logic [NUM_W-1:0] num,
    output logic             sel_data,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic             start_err
);

    localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(CLK_FREQ / 9600);
    localparam logic [NUM_W-1:0] LAST_BIT  = NUM_W'(FRAME_BITS - 1);

    state_e           state_q, state_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic             start_err_q, start_err_d;

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;
    logic             mid;
    logic             wrap;
    logic             run;

    assign run  = (state_q == BIT);
    assign half = {1'b0, div_q[CNT_W-1:1]};

    uart_baud_cnt u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .div  (div_q),
        .half (half),
        .cnt  (cnt),
        .mid  (mid),
        .wrap (wrap)
    );

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        div_d        = div_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        start_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                num_d = '0;
                if (rx_en && rx_enable) begin
                    state_d = BIT;
                    div_d   = baud_div(baud_sel, CLK_FREQ);
                end
            end
            BIT: begin
                // Stop check returns to IDLE half a bit early so back-to-back frames are caught.
                if (mid && (num_q == '0) && rs232_rx) begin
                    state_d     = IDLE;
                    num_d       = '0;
                    start_err_d = 1'b1;
                end else if (mid && (num_q == LAST_BIT)) begin
                    state_d      = IDLE;
                    num_d        = '0;
                    frame_done_d = 1'b1;
                    frame_err_d  = !rs232_rx;
                end else if (wrap) begin
                    num_d = num_q + NUM_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            num_q        <= '0;
            div_q        <= DIV_RESET;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            div_q        <= div_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            start_err_q  <= start_err_d;
        end
    end

    assign num        = num_q;
    assign busy       = run;
    assign sel_data   = run && (cnt == half);
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign start_err  = start_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_enable = 1'b0;
    logic [1:0] baud_sel = 2'd3;
    logic       rx_en = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [3:0] num;
    logic       sel_data, busy, frame_done, frame_err, start_err;

    uart_rx_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rx_enable  (rx_enable),
        .baud_sel   (baud_sel),
        .rx_en      (rx_en),
        .rs232_rx   (rs232_rx),
        .num        (num),
        .sel_data   (sel_data),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .start_err  (start_err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Line model: mode 0 idle high, 1 framed bits of line_div cycles, 2 glitch low for 50 cycles.
    int         line_mode = 0;
    longint     line_t0 = 0;
    longint     line_div = 434;
    logic [9:0] line_frame = 10'h3ff;
    longint     line_d;
    longint     line_idx;

    always @(negedge clk) begin
        #1;
        line_d = cyc - line_t0;
        if (line_mode == 0) begin
            rs232_rx = 1'b1;
        end else if (line_mode == 2) begin
            rs232_rx = (line_d < 50) ? 1'b0 : 1'b1;
        end else begin
            line_idx = line_d / line_div;
            rs232_rx = (line_idx < 10) ? line_frame[line_idx] : 1'b1;
        end
    end

    longint s_cyc[$];
    longint s_num[$];
    longint d_cyc[$];
    longint fe_cyc[$];
    longint se_cyc[$];
    int     overlap = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (sel_data) begin
                s_cyc.push_back(cyc);
                s_num.push_back(longint'(num));
            end
            if (frame_done) d_cyc.push_back(cyc);
            if (frame_err)  fe_cyc.push_back(cyc);
            if (start_err)  se_cyc.push_back(cyc);
            if (sel_data && (frame_done || frame_err || start_err)) overlap++;
        end
    end

    task automatic wait_until(input longint c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({tag, "_timeout"}, 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic start_frame(input logic [1:0] bs, input int mode, input longint div,
                               input logic [7:0] data, input logic stop, output longint t);
        @(negedge clk);
        s_cyc.delete(); s_num.delete(); d_cyc.delete(); fe_cyc.delete(); se_cyc.delete();
        t          = cyc;
        baud_sel   = bs;
        line_t0    = t;
        line_div   = div;
        line_frame = {stop, data, 1'b0};
        line_mode  = mode;
        rx_en      = 1'b1;
        @(negedge clk);
        rx_en = 1'b0;
    endtask

    task automatic check_frame(input string tag, input longint t, input logic exp_ferr);
        check({tag, "_strobes"}, s_cyc.size(), 10);
        for (int k = 0; k < 10 && k < s_cyc.size(); k++) begin
            check($sformatf("%s_strobe%0d_cyc", tag, k), s_cyc[k] - t, 218 + 434 * k);
            check($sformatf("%s_strobe%0d_num", tag, k), s_num[k], k);
        end
        check({tag, "_done_cnt"}, d_cyc.size(), 1);
        if (d_cyc.size() > 0) check({tag, "_done_cyc"}, d_cyc[0] - t, 4125);
        check({tag, "_ferr_cnt"}, fe_cyc.size(), exp_ferr ? 1 : 0);
        if (exp_ferr && fe_cyc.size() > 0) check({tag, "_ferr_cyc"}, fe_cyc[0] - t, 4125);
        check({tag, "_serr_cnt"}, se_cyc.size(), 0);
    endtask

    longint t;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_num", num, 0);
        check("rst_busy", busy, 0);
        check("rst_sel", sel_data, 0);
        check("rst_status", {frame_done, frame_err, start_err}, 0);
        rst = 1'b0;
        rx_enable = 1'b1;
        repeat (2) @(negedge clk);

        // 1: clean frame at 115200
        start_frame(2'd3, 1, 434, 8'h5a, 1'b1, t);
        wait_idle("s1", 6000);
        check_frame("s1", t, 1'b0);

        // 2: glitch start
        start_frame(2'd3, 2, 434, 8'h00, 1'b1, t);
        wait_until(t + 219);
        check("s2_busy_at_219", busy, 0);
        repeat (1000) @(negedge clk);
        check("s2_strobes", s_cyc.size(), 1);
        if (s_cyc.size() > 0) begin
            check("s2_strobe_cyc", s_cyc[0] - t, 218);
            check("s2_strobe_num", s_num[0], 0);
        end
        check("s2_serr_cnt", se_cyc.size(), 1);
        if (se_cyc.size() > 0) check("s2_serr_cyc", se_cyc[0] - t, 219);
        check("s2_done_cnt", d_cyc.size(), 0);
        line_mode = 0;

        // 3: framing error
        start_frame(2'd3, 1, 434, 8'hc3, 1'b0, t);
        wait_idle("s3", 6000);
        check_frame("s3", t, 1'b1);

        // 4: baud change mid-frame, then a 9600 frame cut short by reset
        start_frame(2'd3, 1, 434, 8'h96, 1'b1, t);
        wait_until(t + 218 + 2 * 434 + 1);
        baud_sel = 2'd0;
        wait_idle("s4a", 6000);
        check("s4a_strobes", s_cyc.size(), 10);
        if (s_cyc.size() == 10) begin
            check("s4a_span", s_cyc[9] - s_cyc[0], 9 * 434);
            check("s4a_gap9", s_cyc[9] - s_cyc[8], 434);
        end
        start_frame(2'd0, 1, 5208, 8'h33, 1'b1, t);
        wait_until(t + 2605 + 5208 + 2);
        check("s4b_strobes", s_cyc.size(), 2);
        if (s_cyc.size() >= 2) begin
            check("s4b_first", s_cyc[0] - t, 2605);
            check("s4b_gap", s_cyc[1] - s_cyc[0], 5208);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        line_mode = 0;
        repeat (2) @(negedge clk);

        // 5: rx_en mid-frame ignored, rx_enable dropped mid-frame
        start_frame(2'd3, 1, 434, 8'h5a, 1'b1, t);
        wait_until(t + 218 + 4 * 434);
        rx_en = 1'b1;
        @(negedge clk);
        rx_en = 1'b0;
        wait_until(t + 218 + 6 * 434);
        rx_enable = 1'b0;
        wait_idle("s5", 6000);
        check_frame("s5", t, 1'b0);
        rx_en = 1'b1;
        @(negedge clk);
        rx_en = 1'b0;
        repeat (300) @(negedge clk);
        check("s5_idle_busy", busy, 0);
        check("s5_idle_num", num, 0);
        check("s5_idle_strobes", s_cyc.size(), 10);
        rx_enable = 1'b1;

        // 6: asynchronous reset mid-frame, then a normal frame
        start_frame(2'd3, 1, 434, 8'h5a, 1'b1, t);
        wait_until(t + 218 + 5 * 434);
        check("s6_pre_sel", sel_data, 1);
        check("s6_pre_num", num, 5);
        #2 rst = 1'b1;
        #1;
        check("s6_rst_num", num, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_sel", sel_data, 0);
        @(negedge clk);
        rst = 1'b0;
        line_mode = 0;
        repeat (5) @(negedge clk);
        check("s6_post_busy", busy, 0);
        start_frame(2'd3, 1, 434, 8'h5a, 1'b1, t);
        wait_idle("s6", 6000);
        check_frame("s6", t, 1'b0);

        check("overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
